// File: rtl/restoring_divider.sv
// 16-by-8 unsigned restoring divider: one quotient bit per clock, MSB first.
// Results appear on registered outputs only when a division completes.
module restoring_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [15:0] shift_q;
  logic [7:0]  div_q;
  logic [7:0]  part_q;
  logic [3:0]  cnt;

  logic [8:0]  shifted;
  logic [8:0]  diff;
  logic        ge;
  logic [15:0] shift_nxt;
  logic [7:0]  part_nxt;
  logic        last_iter;

  // One restoring step. The partial remainder is always below the divisor,
  // so after the shift it fits 9 bits and the result fits back into 8.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output
    // first, so no value is held over from a previous evaluation (no latch).
    shifted   = {part_q, shift_q[15]};
    diff      = shifted - {1'b0, div_q};
    ge        = (shifted >= {1'b0, div_q});
    shift_nxt = {shift_q[14:0], ge};
    part_nxt  = ge ? diff[7:0] : shifted[7:0];
  end

  assign last_iter = (cnt == 4'd15);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == 8'd0) ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: sequential state is written with non-blocking '<=' so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift_q     <= '0;
      div_q       <= '0;
      part_q      <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            shift_q <= dividend;
            div_q   <= divisor;
            part_q  <= '0;
            cnt     <= '0;
            if (divisor == 8'd0) begin
              quotient    <= 16'hFFFF;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          shift_q <= shift_nxt;
          part_q  <= part_nxt;
          cnt     <= cnt + 4'd1;
          if (last_iter) begin
            quotient    <= shift_nxt;
            remainder   <= part_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
